// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults, chunk helpers and stage flag type for the pipelined adder
//
// Purpose : Default geometry of adder_pipe_param, the chunk-width derivation,
//           the WIDTH/STAGES legality test used at elaboration, and the packed
//           {valid, carry} flag describing one pipeline stage.
// Ports   : none (package)

package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // One pipeline stage as seen from outside: does it hold a live operand set,
  // and what carry did its chunk produce.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_flag_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The carry chain is cut into equal slices, so the split must be exact and
  // every stage must own at least one bit.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - one registered CHUNK-bit slice of the carry chain
//
// Purpose : Adds one chunk of the operands plus an incoming carry and registers
//           the chunk sum and its carry-out. Holds its outputs unless en is high.
// Ports   : clk      in   rising-edge clock
//           rst      in   synchronous active-high reset (clears s_chunk, cout)
//           en       in   load a new chunk result this cycle
//           a_chunk  in   CHUNK-bit slice of operand A
//           b_chunk  in   CHUNK-bit slice of operand B
//           cin      in   carry into bit 0 of the slice
//           s_chunk  out  registered CHUNK-bit slice sum
//           cout     out  registered carry out of the slice MSB

module adder_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK = chunk_width(DEF_WIDTH, DEF_STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             cin,
  output logic [CHUNK-1:0] s_chunk,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      s_chunk <= '0;
      cout    <= 1'b0;
    end else if (en) begin
      s_chunk <= total[CHUNK-1:0];
      cout    <= total[CHUNK];
    end
  end

endmodule

// File: rtl/adder_pipe_param.sv
// rtl/adder_pipe_param.sv - WIDTH-bit adder pipelined into STAGES carry-chained chunks
//
// Purpose : {c_out, sum} = a + b + c_in, one chunk of the carry chain per stage,
//           valid/ready on both sides, one result per clock, full stall under
//           backpressure. Optional macro ADDER_OVF_EN adds the signed overflow
//           output ovf together with the operand-MSB pipeline that feeds it.
// Ports   : clk        in   rising-edge clock
//           rst        in   synchronous active-high reset, flushes all in-flight sets
//           in_valid   in   a/b/c_in valid this cycle
//           in_ready   out  operand set accepted this cycle (combinational)
//           a, b       in   WIDTH-bit operands
//           c_in       in   carry in
//           out_valid  out  sum/c_out/q valid
//           out_ready  in   consumer takes the result this cycle
//           sum        out  (a+b+c_in) mod 2^WIDTH
//           c_out      out  carry out of bit WIDTH-1
//           q          out  {c_out, sum}
//           ovf        out  signed overflow (ADDER_OVF_EN only)

module adder_pipe_param
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [WIDTH:0]   q
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("adder_pipe_param: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              adv;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] cout;
  stage_flag_t       out_flag;

  // The whole pipe moves as one: it advances whenever the output register is
  // empty or being drained this cycle, otherwise every register freezes.
  assign adv      = ~vld[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Data registers only load behind a live set; bubbles move the valid bits
  // but leave data untouched, which is what keeps sum/q stable between results.
  always_comb begin
    load    = '0;
    load[0] = adv & in_valid;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv & vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  // Stage k sees a_pend/b_pend: the operand bits from chunk k upward, delayed
  // k cycles. It consumes the low chunk and hands the rest to stage k+1.
  // sum_done collects chunk sums 0..k so the lower results ride along and
  // line up with the top chunk at the output.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-k*CHUNK-1:0] a_pend;
    logic [WIDTH-k*CHUNK-1:0] b_pend;
    logic [(k+1)*CHUNK-1:0]   sum_done;
    logic [CHUNK-1:0]         s_chunk;
    logic                     cin;

    if (k == 0) begin : g_first
      assign a_pend   = a;
      assign b_pend   = b;
      assign cin      = c_in;
      assign sum_done = s_chunk;
    end else begin : g_next
      logic [k*CHUNK-1:0] sum_lo;

      // Upper operand bits move one stage while the set itself enters
      // stage k-1, so they are waiting when the set reaches stage k.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_pend <= '0;
          b_pend <= '0;
        end else if (load[k-1]) begin
          a_pend <= g_stage[k-1].a_pend[WIDTH-(k-1)*CHUNK-1:CHUNK];
          b_pend <= g_stage[k-1].b_pend[WIDTH-(k-1)*CHUNK-1:CHUNK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_lo <= '0;
        end else if (load[k]) begin
          sum_lo <= g_stage[k-1].sum_done;
        end
      end

      assign cin      = cout[k-1];
      assign sum_done = {s_chunk, sum_lo};
    end

    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .clk    (clk),
      .rst    (rst),
      .en     (load[k]),
      .a_chunk(a_pend[CHUNK-1:0]),
      .b_chunk(b_pend[CHUNK-1:0]),
      .cin    (cin),
      .s_chunk(s_chunk),
      .cout   (cout[k])
    );

    if (k == STAGES-1) begin : g_last
      assign sum = sum_done;
    end
  end

  assign out_flag  = {vld[STAGES-1], cout[STAGES-1]};
  assign out_valid = out_flag.valid;
  assign c_out     = out_flag.carry;
  assign q         = {c_out, sum};

`ifdef ADDER_OVF_EN
  logic [STAGES-1:0] a_msb;
  logic [STAGES-1:0] b_msb;

  // Operand sign bits travel with the set so the final sum MSB can be judged
  // against the operands it came from.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= '0;
      b_msb <= '0;
    end else begin
      if (load[0]) begin
        a_msb[0] <= a[WIDTH-1];
        b_msb[0] <= b[WIDTH-1];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          a_msb[k] <= a_msb[k-1];
          b_msb[k] <= b_msb[k-1];
        end
      end
    end
  end

  assign ovf = (a_msb[STAGES-1] == b_msb[STAGES-1]) & (sum[WIDTH-1] != a_msb[STAGES-1]);
`endif

endmodule

// File: tb/tb_adder_pipe_param.sv
// tb/tb_adder_pipe_param.sv - self-checking bench for adder_pipe_param

module tb_adder_pipe_param;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic [WIDTH:0]   q;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH:0] q;
    logic           ovf;
  } exp_t;

  exp_t exp_q[$];

  adder_pipe_param #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .q        (q)
`ifdef ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum in WIDTH+1 bits, sign rule on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    exp_t e;
    logic [WIDTH:0] full;
    full  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    e.q   = full;
    e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(WIDTH-1){1'b1}}};
      3:       v = {1'b1, {(WIDTH-1){1'b0}}};
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < STAGES + 2; i++) begin
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out: got %b want 0", c_out); end
    total++; if (q !== '0) begin bad++; $display("FAIL reset_q: got %h want 0", q); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    for (int t = 0; t < STAGES + 2; t++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_discard: cycle %0d got out_valid=%b want 0", t, out_valid); end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = '0; c_in = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wrap_accept: got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= STAGES + 1; t++) begin
      #1;
      if (t == STAGES) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_latency: got out_valid=%b want 1 at cycle %0d", out_valid, t); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL wrap_sum: got %h want 0", sum); end
        total++; if (c_out !== 1'b1) begin bad++; $display("FAIL wrap_c_out: got %b want 1", c_out); end
        total++; if (q !== 33'h1_0000_0000) begin bad++; $display("FAIL wrap_q: got %h want 100000000", q); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_early_late: got out_valid=%b want 0 at cycle %0d", out_valid, t); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ta[3];
    logic [WIDTH-1:0] tb[3];
    logic             tc[3];
    logic [WIDTH:0]   want[3];
    ta = '{32'd1, 32'hFFFF_0000, 32'd5};
    tb = '{32'd2, 32'h0001_0000, 32'd7};
    tc = '{1'b0, 1'b0, 1'b1};
    want = '{33'd3, 33'h1_0000_0000, 33'd13};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < STAGES + 5; cyc++) begin
      if (cyc < 3) begin
        in_valid = 1'b1; a = ta[cyc]; b = tb[cyc]; c_in = tc[cyc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= STAGES && cyc < STAGES + 3) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: cycle %0d got %b want 1", cyc, out_valid); end
        total++; if (q !== want[cyc-STAGES]) begin bad++; $display("FAIL b2b_q: result %0d got %h want %h", cyc - STAGES, q, want[cyc-STAGES]); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble: cycle %0d got out_valid=%b want 0", cyc, out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] pa[5];
    logic [WIDTH-1:0] pb[5];
    logic             pc[5];
    exp_t             e;
    int               sent = 0;
    int               cyc  = 0;
    for (int i = 0; i < 5; i++) begin
      pa[i] = pick(); pb[i] = pick(); pc[i] = 1'($urandom_range(0, 1));
    end
    while ((sent < 5 || exp_q.size() != 0) && cyc < STAGES + 40) begin
      out_ready = !(cyc >= STAGES && cyc < STAGES + 3);
      in_valid  = (sent < 5);
      if (sent < 5) begin a = pa[sent]; b = pb[sent]; c_in = pc[sent]; end
      #1;
      if (!out_ready) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_valid: got %b want 1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_in_ready: got %b want 0", in_ready); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_stall_hold: nothing expected, got q=%h", q); end
        else if (q !== exp_q[0].q) begin bad++; $display("FAIL bp_stall_hold: got %h want %h", q, exp_q[0].q); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, c_in));
        sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_spurious: got out_valid=1 want 0"); end
        else begin
          e = exp_q.pop_front();
          if (q !== e.q) begin bad++; $display("FAIL bp_q: got %h want %h", q, e.q); end
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (sent != 5 || exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: sent %0d pending %0d want 5 and 0", sent, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = pick(); b = pick(); c_in = 1'($urandom_range(0, 1));
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_accept: got in_ready=%b want 1", in_ready); end
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < STAGES + 4; t++) begin
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: cycle %0d got %b want 0", t, out_valid); end
      tick();
    end
    total++; if (q !== '0) begin bad++; $display("FAIL flush_q: got %h want 0", q); end
  endtask

  task automatic test_random();
    exp_t           e;
    logic [WIDTH:0] last_q = '0;
    logic           want_ready;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 500) begin
        in_valid = ($urandom_range(0, 9) < 7); a = pick(); b = pick(); c_in = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      want_ready = (out_valid !== 1'b1) || out_ready;
      total++; if (in_ready !== want_ready) begin bad++; $display("FAIL rand_in_ready: got %b want %b", in_ready, want_ready); end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in));
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          total++;
          if (exp_q.size() == 0) begin bad++; $display("FAIL rand_spurious: got out_valid=1 want 0"); end
          else begin
            e = exp_q.pop_front();
            if (q !== e.q || sum !== e.q[WIDTH-1:0] || c_out !== e.q[WIDTH]) begin
              bad++; $display("FAIL rand_result: got q=%h sum=%h c_out=%b want q=%h", q, sum, c_out, e.q);
            end
`ifdef ADDER_OVF_EN
            total++; if (ovf !== e.ovf) begin bad++; $display("FAIL rand_ovf: got %b want %b", ovf, e.ovf); end
`endif
            last_q = e.q;
          end
        end
      end else begin
        total++; if (q !== last_q) begin bad++; $display("FAIL rand_hold: got %h want %h", q, last_q); end
      end
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain: pending %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    logic [WIDTH-1:0] oa[2];
    logic [WIDTH-1:0] ob[2];
    logic [WIDTH-1:0] want_sum[2];
    logic             want_ovf[2];
    logic             want_c[2];
    oa = '{32'h7FFF_FFFF, 32'hFFFF_FFFF};
    ob = '{32'h0000_0001, 32'h0000_0001};
    want_sum = '{32'h8000_0000, 32'h0000_0000};
    want_ovf = '{1'b1, 1'b0};
    want_c   = '{1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = oa[i]; b = ob[i]; c_in = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int t = 0; t < STAGES + 4 && out_valid !== 1'b1; t++) tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_timeout: set %0d got out_valid=%b want 1", i, out_valid); end
      total++; if (sum !== want_sum[i]) begin bad++; $display("FAIL ovf_sum: set %0d got %h want %h", i, sum, want_sum[i]); end
      total++; if (ovf !== want_ovf[i]) begin bad++; $display("FAIL ovf_flag: set %0d got %b want %b", i, ovf, want_ovf[i]); end
      total++; if (c_out !== want_c[i]) begin bad++; $display("FAIL ovf_c_out: set %0d got %b want %b", i, c_out, want_c[i]); end
      tick();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
    test_reset();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
